// File: rtl/fredkin_jk_counter_pkg.sv
// Shared constants for the reversible-logic counter: Fredkin constant inputs
// and the default counter width.
package fredkin_jk_counter_pkg;

    localparam logic REV_C0            = 1'b0;
    localparam logic REV_C1            = 1'b1;
    localparam int   DEFAULT_CNT_WIDTH = 4;

endpackage

// File: rtl/fredkin.sv
// Fredkin (controlled-swap) gate: p = a, q = a ? c : b, r = a ? b : c.
module fredkin (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic p_o,
    output logic q_o,
    output logic r_o
);

    assign p_o = a_i;
    assign q_o = a_i ? c_i : b_i;
    assign r_o = a_i ? b_i : c_i;

endmodule

// File: rtl/fredkin_jk_cell.sv
// One counter bit: toggle-carry propagation, JK (J=K=t) next state and load
// mux, all built from Fredkin gates.
module fredkin_jk_cell
    import fredkin_jk_counter_pkg::*;
(
    input  logic t_in,
    input  logic q,
    input  logic qb,
    input  logic up,
    input  logic load,
    input  logic d,
    output logic t_out,
    output logic q_next
);

    logic        s;
    logic        not_t;
    logic        j_term;
    logic        k_term;
    logic        jk_next;
    logic [13:0] garbage_unused;

    // s = up ? q : qb selects which polarity carries the toggle upward
    fredkin u_sel (
        .a_i(up), .b_i(qb), .c_i(q),
        .p_o(garbage_unused[0]), .q_o(s), .r_o(garbage_unused[1])
    );

    fredkin u_carry (
        .a_i(t_in), .b_i(s), .c_i(REV_C0),
        .p_o(garbage_unused[2]), .q_o(garbage_unused[3]), .r_o(t_out)
    );

    fredkin u_inv_t (
        .a_i(t_in), .b_i(REV_C0), .c_i(REV_C1),
        .p_o(garbage_unused[4]), .q_o(garbage_unused[5]), .r_o(not_t)
    );

    // q+ = J&~q | ~K&q with J = K = t_in
    fredkin u_j_term (
        .a_i(t_in), .b_i(qb), .c_i(REV_C0),
        .p_o(garbage_unused[6]), .q_o(garbage_unused[7]), .r_o(j_term)
    );

    fredkin u_k_term (
        .a_i(not_t), .b_i(q), .c_i(REV_C0),
        .p_o(garbage_unused[8]), .q_o(garbage_unused[9]), .r_o(k_term)
    );

    fredkin u_or (
        .a_i(j_term), .b_i(k_term), .c_i(REV_C1),
        .p_o(garbage_unused[10]), .q_o(jk_next), .r_o(garbage_unused[11])
    );

    fredkin u_load (
        .a_i(load), .b_i(jk_next), .c_i(d),
        .p_o(garbage_unused[12]), .q_o(q_next), .r_o(garbage_unused[13])
    );

endmodule

// File: rtl/fredkin_jk_counter.sv
// WIDTH-bit up/down counter with parallel load; per-bit Fredkin JK cells feed
// the q/qb registers, tc flags the cycle before a wrap.
module fredkin_jk_counter
    import fredkin_jk_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] qb_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] qb_d;
    logic [WIDTH-1:0] t_in_w;
    logic [WIDTH-1:0] t_out_w;
    logic             t_top_unused;

    // Seeding the toggle chain with en makes en=0 a pure hold in every cell
    assign t_in_w[0]         = en;
    assign t_in_w[WIDTH-1:1] = t_out_w[WIDTH-2:0];
    assign t_top_unused      = t_out_w[WIDTH-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fredkin_jk_cell u_cell (
            .t_in  (t_in_w[i]),
            .q     (q_q[i]),
            .qb    (qb_q[i]),
            .up    (up),
            .load  (load),
            .d     (din[i]),
            .t_out (t_out_w[i]),
            .q_next(q_d[i])
        );
    end

    assign qb_d = ~q_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q_q  <= '0;
            qb_q <= '1;
        end else begin
            q_q  <= q_d;
            qb_q <= qb_d;
        end
    end

    assign q  = q_q;
    assign qb = qb_q;
    assign tc = en & (up ? (&q_q) : ~(|q_q));

endmodule
